matrix_mac_engine: RTL

MATRIX_MAC_ENGINE -- requirements
Module: matrix_mac_engine

---
 rtl/matrix_mac_engine.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/matrix_mac_engine.sv
// NxN unsigned matrix multiply C = A x B, one multiply-accumulate per clock.
// Define MATMUL_SAT_EN to saturate write-back at 2^DW-1 and report it on a sticky ovf flag.
module matrix_mac_engine #(
    parameter int N  = 4,
    parameter int DW = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   wr_en,
    input  logic                   wr_sel,
    input  logic [$clog2(N*N)-1:0] wr_addr,
    input  logic [DW-1:0]          wr_data,
    input  logic                   start,
    output logic                   busy,
    output logic                   done,
    input  logic [$clog2(N*N)-1:0] rd_addr,
    output logic [DW-1:0]          rd_data,
    output logic                   ovf
);
    localparam int AW   = $clog2(N*N);
    localparam int NN   = N*N;
    localparam int CW   = $clog2(N);
    localparam int ACCW = 2*DW + $clog2(N);
    localparam logic [AW:0]   NN_LIM = (AW+1)'(NN);
    localparam logic [CW-1:0] LAST   = CW'(N-1);

    typedef enum logic [1:0] {IDLE, MAC, WRITE, DONE} state_t;

    state_t            state_reg;
    logic              busy_reg;
    logic              done_reg;
    logic              ovf_reg;
    logic [DW-1:0]     rd_data_reg;
    logic [ACCW-1:0]   acc_reg;
    logic [CW-1:0]     i_reg;
    logic [CW-1:0]     j_reg;
    logic [CW-1:0]     k_reg;
    logic [DW-1:0]     a_reg [NN];
    logic [DW-1:0]     b_reg [NN];
    logic [DW-1:0]     c_reg [NN];

    logic [AW-1:0]     a_idx;
    logic [AW-1:0]     b_idx;
    logic [AW-1:0]     c_idx;
    logic [ACCW-1:0]   prod;
    logic [DW-1:0]     wb_data;
    logic              wr_ok;
    logic              rd_ok;

    assign a_idx = AW'(i_reg * N + k_reg);
    assign b_idx = AW'(k_reg * N + j_reg);
    assign c_idx = AW'(i_reg * N + j_reg);
    assign prod  = ACCW'(a_reg[a_idx]) * ACCW'(b_reg[b_idx]);
    assign wr_ok = ({1'b0, wr_addr} < NN_LIM);
    assign rd_ok = ({1'b0, rd_addr} < NN_LIM);

`ifdef MATMUL_SAT_EN
    logic acc_over;
    assign acc_over = |acc_reg[ACCW-1:DW];
    assign wb_data  = acc_over ? {DW{1'b1}} : acc_reg[DW-1:0];
`else
    assign wb_data  = acc_reg[DW-1:0];
`endif

    assign busy    = busy_reg;
    assign done    = done_reg;
    assign ovf     = ovf_reg;
    assign rd_data = rd_data_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b0;
            ovf_reg   <= 1'b0;
            acc_reg   <= '0;
            i_reg     <= '0;
            j_reg     <= '0;
            k_reg     <= '0;
            for (int e = 0; e < NN; e++) begin
                a_reg[e] <= '0;
                b_reg[e] <= '0;
                c_reg[e] <= '0;
            end
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    // Operand write and start may share an edge; MAC reads the array a cycle later.
                    if (wr_en && wr_ok) begin
                        if (wr_sel) b_reg[wr_addr] <= wr_data;
                        else        a_reg[wr_addr] <= wr_data;
                    end
                    if (start) begin
                        state_reg <= MAC;
                        busy_reg  <= 1'b1;
                        ovf_reg   <= 1'b0;
                        acc_reg   <= '0;
                        i_reg     <= '0;
                        j_reg     <= '0;
                        k_reg     <= '0;
                    end
                end
                MAC: begin
                    acc_reg <= acc_reg + prod;
                    if (k_reg == LAST) begin
                        k_reg     <= '0;
                        state_reg <= WRITE;
                    end else begin
                        k_reg <= k_reg + 1'b1;
                    end
                end
                WRITE: begin
                    c_reg[c_idx] <= wb_data;
                    acc_reg      <= '0;
`ifdef MATMUL_SAT_EN
                    if (acc_over) ovf_reg <= 1'b1;
`endif
                    if (j_reg == LAST) begin
                        j_reg <= '0;
                        if (i_reg == LAST) begin
                            state_reg <= DONE;
                            busy_reg  <= 1'b0;
                        end else begin
                            i_reg     <= i_reg + 1'b1;
                            state_reg <= MAC;
                        end
                    end else begin
                        j_reg     <= j_reg + 1'b1;
                        state_reg <= MAC;
                    end
                end
                DONE: begin
                    done_reg  <= 1'b1;
                    state_reg <= IDLE;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) rd_data_reg <= '0;
        else     rd_data_reg <= rd_ok ? c_reg[rd_addr] : '0;
    end
endmodule
